// File: rtl/alu_pkg.sv
// Shared definitions for the ALU pipeline core.
// Contents: opcode encodings for the sel field, FSM state type.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_pipe_core_if.sv
// Request/result bus of the ALU pipeline core.
// Request side : in_valid, in_ready, a, b, sel
// Result side  : out_valid, out_ready, out, zero, carry, overflow, error
// master = requester/consumer, slave = the ALU core.
interface alu_pipe_core_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             error;

  modport master (
    output in_valid, a, b, sel, out_ready,
    input  in_ready, out_valid, out, zero, carry, overflow, error
  );

  modport slave (
    input  in_valid, a, b, sel, out_ready,
    output in_ready, out_valid, out, zero, carry, overflow, error
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier, one partial product per cycle.
// Ports: clk, rst_n (sync, active-low), start (load operands),
//        a, b (operands), done (final step this cycle),
//        product (2*WIDTH, valid while done is high).
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] step_acc;

  // Product is the accumulator after the step taking effect at the next
  // edge, so the caller can capture it on the same edge as the last step.
  assign step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done     = (cnt_q == CW'(1));
  assign product  = step_acc;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = CW'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_d    = step_acc;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/alu_pipe_core.sv
// ALU core with valid/ready handshake on both sides.
// Single-cycle ops complete one cycle after acceptance; MUL runs through
// the sequential multiplier. Result and flags are held until consumed.
// Ports: clk, rst_n (sync, active-low), bus (alu_pipe_core_if.slave).
//
// state | meaning
// IDLE  | ready for a request
// EXEC  | multiplier stepping
// DONE  | result valid, waiting for out_ready
module alu_pipe_core #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_pipe_core_if.slave  bus
);
  import alu_pkg::*;

  localparam int              MSB       = WIDTH - 1;
  localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;

  logic               accept, mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH:0]     sum_ext, shl_ext, shr_ext;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v, alu_e;

  assign bus.in_ready  = (state_q == IDLE) & rst_n;
  assign accept        = bus.in_valid & bus.in_ready;
  assign mul_start     = accept & (bus.sel == OP_MUL);

  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.error     = err_q;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Extra bit on the shifts catches the last bit shifted out: the MSB for
  // SHL, the LSB for SHR; both stay 0 when b == 0.
  always_comb begin
    sum_ext = {1'b0, bus.a} + {1'b0, bus.b};
    shl_ext = {1'b0, bus.a} << bus.b;
    shr_ext = {bus.a, 1'b0} >> bus.b;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_e   = 1'b0;
    case (bus.sel)
      OP_ADD: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (bus.a[MSB] == bus.b[MSB]) & (alu_res[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        alu_res = bus.a - bus.b;
        alu_c   = bus.a < bus.b;
        alu_v   = (bus.a[MSB] != bus.b[MSB]) & (alu_res[MSB] != bus.a[MSB]);
      end
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_SHL: begin
        if (bus.b >= SHIFT_LIM) begin
          alu_e = 1'b1;
        end else begin
          alu_res = shl_ext[WIDTH-1:0];
          alu_c   = shl_ext[WIDTH];
        end
      end
      OP_SHR: begin
        if (bus.b >= SHIFT_LIM) begin
          alu_e = 1'b1;
        end else begin
          alu_res = shr_ext[WIDTH:1];
          alu_c   = shr_ext[0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.sel == OP_MUL) begin
            state_d = EXEC;
          end else begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_d       = alu_res;
            zero_d      = (alu_res == '0);
            carry_d     = alu_c;
            ovf_d       = alu_v;
            err_d       = alu_e;
          end
        end
      end
      EXEC: begin
        if (mul_done) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_d       = mul_product[WIDTH-1:0];
          zero_d      = (mul_product[WIDTH-1:0] == '0);
          carry_d     = |mul_product[2*WIDTH-1:WIDTH];
          ovf_d       = 1'b0;
          err_d       = 1'b0;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_alu_pipe_core.sv
module tb_alu_pipe_core;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_pipe_core_if #(.WIDTH(8)) bus ();

  alu_pipe_core #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, required finish before 200000");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
    logic [7:0] o;
    logic [3:0] f;   // {zero, carry, overflow, error}
  } vec_t;

  // Starts and ends just after a falling edge. lat counts falling edges
  // from the accepting edge until out_valid is seen (1 = next cycle).
  task automatic send(input logic [7:0] ta, input logic [7:0] tbv,
                      input logic [2:0] ts, input bit junk,
                      output int lat, output int ready_hi);
    bus.a        = ta;
    bus.b        = tbv;
    bus.sel      = ts;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat          = 1;
    ready_hi     = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      if (bus.in_ready !== 1'b0) ready_hi++;
      if (junk) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.a        = 8'($urandom);
        bus.b        = 8'($urandom);
        bus.sel      = 3'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 8'hFF;
    bus.b         = 8'h01;
    bus.sel       = OP_ADD;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_in_ready_low: got %b want 0", bus.in_ready);
    end
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready_release: got %b want 1", bus.in_ready);
    end
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    total++;
    if (bus.out !== 8'h00) begin
      bad++; $display("FAIL reset_out: got %h want 00", bus.out);
    end
    total++;
    if ({bus.zero, bus.carry, bus.overflow, bus.error} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b want 0000",
                      {bus.zero, bus.carry, bus.overflow, bus.error});
    end
  endtask

  task automatic test_single_cycle();
    vec_t vecs [17];
    int   lat, rdy;
    vecs[0]  = {8'h7F, 8'h01, OP_ADD, 8'h80, 4'b0010};
    vecs[1]  = {8'hFF, 8'h01, OP_ADD, 8'h00, 4'b1100};
    vecs[2]  = {8'h80, 8'h80, OP_ADD, 8'h00, 4'b1110};
    vecs[3]  = {8'h00, 8'h01, OP_SUB, 8'hFF, 4'b0100};
    vecs[4]  = {8'h80, 8'h01, OP_SUB, 8'h7F, 4'b0010};
    vecs[5]  = {8'h05, 8'h05, OP_SUB, 8'h00, 4'b1000};
    vecs[6]  = {8'h7F, 8'hFF, OP_SUB, 8'h80, 4'b0110};
    vecs[7]  = {8'hF0, 8'h3C, OP_AND, 8'h30, 4'b0000};
    vecs[8]  = {8'hF0, 8'h0F, OP_OR,  8'hFF, 4'b0000};
    vecs[9]  = {8'hAA, 8'hAA, OP_XOR, 8'h00, 4'b1000};
    vecs[10] = {8'h81, 8'h01, OP_SHL, 8'h02, 4'b0100};
    vecs[11] = {8'h81, 8'h00, OP_SHL, 8'h81, 4'b0000};
    vecs[12] = {8'h01, 8'h07, OP_SHL, 8'h80, 4'b0000};
    vecs[13] = {8'hFF, 8'h09, OP_SHL, 8'h00, 4'b1001};
    vecs[14] = {8'h01, 8'h08, OP_SHR, 8'h00, 4'b1001};
    vecs[15] = {8'h81, 8'h01, OP_SHR, 8'h40, 4'b0100};
    vecs[16] = {8'h80, 8'h07, OP_SHR, 8'h01, 4'b0000};
    for (int i = 0; i < 17; i++) begin
      total++;
      if (bus.in_ready !== 1'b1) begin
        bad++; $display("FAIL sc%0d_ready_before: got %b want 1", i, bus.in_ready);
      end
      send(vecs[i].a, vecs[i].b, vecs[i].sel, 1'b0, lat, rdy);
      total++;
      if (lat !== 1) begin
        bad++; $display("FAIL sc%0d_latency: got %0d want 1", i, lat);
      end
      total++;
      if (bus.out !== vecs[i].o) begin
        bad++; $display("FAIL sc%0d_out: got %h want %h", i, bus.out, vecs[i].o);
      end
      total++;
      if ({bus.zero, bus.carry, bus.overflow, bus.error} !== vecs[i].f) begin
        bad++; $display("FAIL sc%0d_flags(zcve): got %b want %b", i,
                        {bus.zero, bus.carry, bus.overflow, bus.error}, vecs[i].f);
      end
      pop();
    end
  endtask

  task automatic test_mul();
    logic [7:0] ma [3];
    logic [7:0] mb [3];
    logic [7:0] mo [3];
    logic [3:0] mf [3];
    int         lat, rdy;
    ma[0] = 8'h10; mb[0] = 8'h10; mo[0] = 8'h00; mf[0] = 4'b1100;
    ma[1] = 8'h0D; mb[1] = 8'h0B; mo[1] = 8'h8F; mf[1] = 4'b0000;
    ma[2] = 8'hFF; mb[2] = 8'hFF; mo[2] = 8'h01; mf[2] = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      send(ma[i], mb[i], OP_MUL, 1'b1, lat, rdy);
      total++;
      if (lat !== 9) begin
        bad++; $display("FAIL mul%0d_latency: got %0d want 9", i, lat);
      end
      total++;
      if (rdy !== 0) begin
        bad++; $display("FAIL mul%0d_ready_during_exec: got %0d cycles high want 0", i, rdy);
      end
      total++;
      if (bus.in_ready !== 1'b0) begin
        bad++; $display("FAIL mul%0d_ready_in_done: got %b want 0", i, bus.in_ready);
      end
      total++;
      if (bus.out !== mo[i]) begin
        bad++; $display("FAIL mul%0d_out: got %h want %h", i, bus.out, mo[i]);
      end
      total++;
      if ({bus.zero, bus.carry, bus.overflow, bus.error} !== mf[i]) begin
        bad++; $display("FAIL mul%0d_flags(zcve): got %b want %b", i,
                        {bus.zero, bus.carry, bus.overflow, bus.error}, mf[i]);
      end
      pop();
    end
  endtask

  task automatic test_hold();
    int lat, rdy;
    send(8'hF0, 8'h3C, OP_AND, 1'b0, lat, rdy);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = 8'(i + 1);
      bus.b        = 8'h01;
      bus.sel      = OP_ADD;
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        bad++; $display("FAIL hold%0d_valid_ready: got %b%b want 10", i,
                        bus.out_valid, bus.in_ready);
      end
      total++;
      if (bus.out !== 8'h30 ||
          {bus.zero, bus.carry, bus.overflow, bus.error} !== 4'b0000) begin
        bad++; $display("FAIL hold%0d_result: got %h/%b want 30/0000", i, bus.out,
                        {bus.zero, bus.carry, bus.overflow, bus.error});
      end
    end
    // in_valid stays high across the consuming edge; it must not be taken.
    pop();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL hold_release_valid: got %b want 0", bus.out_valid);
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL hold_release_ready: got %b want 1", bus.in_ready);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL hold_no_accept: got out_valid %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_abort();
    int lat, rdy;
    int seen;
    bus.a        = 8'h10;
    bus.b        = 8'h10;
    bus.sel      = OP_MUL;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL abort_ready_in_reset: got %b want 0", bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL abort_ready_after: got %b want 1", bus.in_ready);
    end
    total++;
    if (bus.out !== 8'h00 || bus.out_valid !== 1'b0 ||
        {bus.zero, bus.carry, bus.overflow, bus.error} !== 4'b0000) begin
      bad++; $display("FAIL abort_outputs: got out=%h v=%b f=%b want 00/0/0000",
                      bus.out, bus.out_valid,
                      {bus.zero, bus.carry, bus.overflow, bus.error});
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL abort_no_valid: got %0d valid cycles want 0", seen);
    end
    send(8'h03, 8'h05, OP_MUL, 1'b0, lat, rdy);
    total++;
    if (lat !== 9 || bus.out !== 8'h0F) begin
      bad++; $display("FAIL abort_next_mul: got lat=%0d out=%h want 9/0f", lat, bus.out);
    end
    pop();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_cycle();
    test_mul();
    test_hold();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_pipe_core.md
ALU_PIPE_CORE -- requirements
Module: alu_pipe_core

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1, request operands/opcode valid.
REQ-005 The block SHALL have port in_ready, output, 1, block can accept a request.
REQ-006 The block SHALL have ports a and b, input, WIDTH each, unsigned operands (two's complement for overflow).
REQ-007 The block SHALL have port sel, input, 3, opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
REQ-008 The block SHALL have port out_valid, output, 1, result and flags valid.
REQ-009 The block SHALL have port out_ready, input, 1, consumer accepts result.
REQ-010 The block SHALL have port out, output, WIDTH, result.
REQ-011 The block SHALL have ports zero, carry, overflow, error, output, 1 each, result flags, registered with out.

Function
REQ-012 The block SHALL use FSM states IDLE, EXEC, DONE; in_ready = (state==IDLE) & rst_n.
REQ-013 The block SHALL accept a request on an edge with in_valid & in_ready, capturing a, b, sel.
REQ-014 For sel != MUL, the block SHALL go IDLE->DONE at acceptance; out_valid=1 the following cycle (latency 1).
REQ-015 For MUL, the block SHALL go IDLE->EXEC, iterate WIDTH shift-add steps (one per cycle), go EXEC->DONE; out_valid first high WIDTH+1 cycles after acceptance.
REQ-016 In DONE, out and all flags SHALL hold stable until out_valid & out_ready, then go DONE->IDLE; no new request accepted in that same cycle.
REQ-017 in_valid while state != IDLE SHALL be ignored; operand changes during EXEC/DONE SHALL not affect the result.
REQ-018 ADD/SUB SHALL be modulo 2^WIDTH; carry = carry-out (ADD) or borrow, i.e. a<b unsigned (SUB).
REQ-019 overflow SHALL be signed overflow: ADD a[W-1]==b[W-1] & out[W-1]!=a[W-1]; SUB a[W-1]!=b[W-1] & out[W-1]!=a[W-1]; 0 for all other ops.
REQ-020 AND/OR/XOR SHALL set carry=0, overflow=0.
REQ-021 SHL/SHR SHALL shift a by b; carry = last bit shifted out (0 if b==0).
REQ-022 SHL/SHR with b >= WIDTH SHALL give out=0, carry=0, error=1; error=0 in every other case.
REQ-023 MUL SHALL give out = low WIDTH bits of a*b; carry=1 iff high WIDTH bits nonzero.
REQ-024 zero SHALL equal (out==0) for every op, including the error case.

Reset
REQ-025 With rst_n low at an edge: state=IDLE; out, out_valid, zero, carry, overflow, error = 0; multiplier state cleared.
REQ-026 Reset in EXEC or DONE SHALL abort the operation with no out_valid pulse; in_ready=1 the first cycle after rst_n rises.

Structure
REQ-027 Package alu_pkg SHALL hold the opcode localparams (OP_ADD..OP_MUL) and the FSM state typedef.
REQ-028 The sequential multiplier SHALL be sub-module alu_mul_seq (start, a, b -> done, product[2*WIDTH-1:0]).
REQ-029 Single-cycle ops SHALL be combinational logic feeding the result register; no latches.

Verification (WIDTH=8)
REQ-030 ADD a=0x7F b=0x01 -> out 0x80, overflow 1, carry 0, zero 0, out_valid 1 cycle after accept.
REQ-031 SUB a=0x00 b=0x01 -> out 0xFF, carry 1, overflow 0; SUB a=0x80 b=0x01 -> out 0x7F, overflow 1.
REQ-032 MUL a=0x10 b=0x10 -> out 0x00, carry 1, zero 1, out_valid 9 cycles after accept; in_ready 0 throughout.
REQ-033 SHL a=0x81 b=1 -> out 0x02, carry 1; SHR a=0x01 b=8 -> out 0x00, error 1, zero 1.
REQ-034 Hold out_ready=0 for 5 cycles after AND a=0xF0 b=0x3C -> out 0x30 stable, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-035 Drop rst_n for 1 cycle 3 cycles into a MUL -> no out_valid, all outputs 0, in_ready 1 after release.
